sr_latch_driver: RTL and testbench



---
 rtl/sr_latch_driver_pkg.sv | 27 ++
 rtl/sync2.sv | 27 ++
 rtl/sr_latch_driver.sv | 160 ++++++++++++++++
 tb/tb_sr_latch_driver.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_driver_pkg.sv
// Shared definitions for the SR latch driver: FSM states, synchronizer depth
// and the sizing rule for the shared timing counter.
package sr_latch_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PULSE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DEAD   = 3'd4
  } state_e;

  // Flops in the feedback synchronizer; the settle window is stretched by this.
  localparam int unsigned SYNC_DEPTH = 2;

  // Width needed to hold the longest timed phase of the sequence.
  function automatic int unsigned cnt_width(input int unsigned pulse_cycles,
                                            input int unsigned settle_cycles,
                                            input int unsigned dead_cycles);
    int unsigned longest;
    longest = pulse_cycles;
    if (settle_cycles + SYNC_DEPTH > longest) longest = settle_cycles + SYNC_DEPTH;
    if (dead_cycles > longest) longest = dead_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous level from the latch cell.
module sync2
  import sr_latch_driver_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] stage_q;
  logic [SYNC_DEPTH-1:0] stage_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    stage_d = {stage_q[SYNC_DEPTH-2:0], d};
  end

  // Synchronizer stages, cleared by reset.
  always_ff @(posedge CLK) begin
    if (!nRST) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign q = stage_q[SYNC_DEPTH-1];

endmodule

// File: rtl/sr_latch_driver.sv
// Drives the active-low set/reset pins of an SR latch cell with a fixed-width
// strobe, waits for the cell to settle, then reads Q/nQ back through a
// synchronizer and flags any disagreement with the requested value.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned DEAD_CYCLES   = 1
) (
  input  logic CLK,
  input  logic nRST,
  input  logic req_valid,
  input  logic req_set,
  output logic req_ready,
  output logic nS,
  output logic nR,
  input  logic Q_fb,
  input  logic nQ_fb,
  output logic done,
  output logic err,
  input  logic err_clr,
  output logic q_state
);

  localparam int unsigned CW = cnt_width(PULSE_CYCLES, SETTLE_CYCLES, DEAD_CYCLES);

  // Counter reload values: a phase of N cycles loads N-1 and exits at zero.
  localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES + SYNC_DEPTH - 1);
  // The dead gap is measured from done, so the CHECK cycle already counts as
  // its first cycle; the DEAD state only covers the remainder.
  localparam logic [CW-1:0] DEAD_LOAD   = CW'((DEAD_CYCLES > 1) ? (DEAD_CYCLES - 2) : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          set_q, set_d;
  logic          ns_q, ns_d;
  logic          nr_q, nr_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic          q_state_q, q_state_d;

  logic          q_sync;
  logic          nq_sync;
  logic          check_fail;

  sync2 u_sync_q (
    .CLK  (CLK),
    .nRST (nRST),
    .d    (Q_fb),
    .q    (q_sync)
  );

  sync2 u_sync_nq (
    .CLK  (CLK),
    .nRST (nRST),
    .d    (nQ_fb),
    .q    (nq_sync)
  );

  // A readback is bad if Q disagrees with the target or Q/nQ are not complementary.
  assign check_fail = (state_q == ST_CHECK) &&
                      ((q_sync != set_q) || (q_sync == nq_sync));

  // Sequencer: next state, shared counter, captured command and readback results.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    set_d     = set_q;
    q_state_d = q_state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          set_d   = req_set;
          cnt_d   = PULSE_LOAD;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_CHECK: begin
        q_state_d = q_sync;
        if (DEAD_CYCLES > 1) begin
          cnt_d   = DEAD_LOAD;
          state_d = ST_DEAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DEAD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error: a failing check wins over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (check_fail)   err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_comb begin
    ns_d    = !((state_d == ST_PULSE) &&  set_d);
    nr_d    = !((state_d == ST_PULSE) && !set_d);
    done_d  = (state_d == ST_CHECK);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      set_q     <= 1'b0;
      ns_q      <= 1'b1;
      nr_q      <= 1'b1;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      q_state_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      set_q     <= set_d;
      ns_q      <= ns_d;
      nr_q      <= nr_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      q_state_q <= q_state_d;
    end
  end

  assign req_ready = ready_q;
  assign nS        = ns_q;
  assign nR        = nr_q;
  assign done      = done_q;
  assign err       = err_q;
  assign q_state   = q_state_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: directed scenarios with literal expectations plus
// a long randomized run checked every cycle against a command-timeline model.
module tb_sr_latch_driver;

  localparam int P = 2;
  localparam int S = 1;
  localparam int D = 1;
  localparam int DONE_K   = P + S + 3;
  localparam int BUSY_END = P + S + 3 + D;

  logic CLK = 1'b0;
  logic nRST;
  logic req_valid;
  logic req_set;
  logic req_ready;
  logic nS;
  logic nR;
  logic Q_fb;
  logic nQ_fb;
  logic done;
  logic err;
  logic err_clr;
  logic q_state;

  // Latch cell stand-in and fault injection.
  logic lat = 1'b0;
  logic stuck = 1'b0;
  logic forbid = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int n_acc = 0;

  always #5 CLK = ~CLK;

  sr_latch_driver #(
    .PULSE_CYCLES  (P),
    .SETTLE_CYCLES (S),
    .DEAD_CYCLES   (D)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_valid (req_valid),
    .req_set   (req_set),
    .req_ready (req_ready),
    .nS        (nS),
    .nR        (nR),
    .Q_fb      (Q_fb),
    .nQ_fb     (nQ_fb),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr),
    .q_state   (q_state)
  );

  // Latch responds one cycle after seeing a strobe.
  always @(posedge CLK) begin
    if (!nS)      lat <= 1'b1;
    else if (!nR) lat <= 1'b0;
  end

  assign Q_fb  = forbid ? 1'b1 : (stuck ? 1'b0 : lat);
  assign nQ_fb = forbid ? 1'b1 : (stuck ? 1'b1 : !lat);

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- reference model and per-cycle compare ----------------
  logic qh  [64];
  logic nqh [64];
  int   c;
  int   k;
  bit   busy;
  int   acc_c;
  logic acc_set;
  logic e_err, e_q, e_ready, e_ns, e_nr, e_done;
  logic qs, nqs;

  initial begin
    for (int i = 0; i < 64; i++) begin
      qh[i]  = 1'b0;
      nqh[i] = 1'b0;
    end
    c = 0; busy = 0; acc_c = 0; acc_set = 0; e_err = 0; e_q = 0;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      c++;
      if (busy && (c - acc_c) >= BUSY_END) busy = 0;
      k       = c - acc_c;
      e_ready = !busy;
      e_ns    = !(busy &&  acc_set && k >= 1 && k <= P);
      e_nr    = !(busy && !acc_set && k >= 1 && k <= P);
      e_done  = busy && (k == DONE_K);

      chk("m_ready",   req_ready, e_ready);
      chk("m_nS",      nS,        e_ns);
      chk("m_nR",      nR,        e_nr);
      chk("m_done",    done,      e_done);
      chk("m_err",     err,       e_err);
      chk("m_q_state", q_state,   e_q);
      chk("strobe_excl", nS | nR, 1'b1);

      qh[c % 64]  = Q_fb;
      nqh[c % 64] = nQ_fb;

      // The check sees feedback as it was two cycles earlier.
      if (e_done) begin
        qs  = qh[(c - 2) % 64];
        nqs = nqh[(c - 2) % 64];
        e_q = qs;
        if (qs != acc_set || qs == nqs) e_err = 1'b1;
        else if (err_clr)              e_err = 1'b0;
      end else if (err_clr) begin
        e_err = 1'b0;
      end

      if (e_ready && req_valid) begin
        busy    = 1;
        acc_c   = c;
        acc_set = req_set;
        n_acc++;
        $display("cmd %0d: accepted set=%0b at t=%0t", n_acc, req_set, $time);
      end

      if (!nRST) begin
        busy  = 0;
        e_err = 1'b0;
        e_q   = 1'b0;
        qh[c % 64]        = 1'b0;
        nqh[c % 64]       = 1'b0;
        qh[(c - 1) % 64]  = 1'b0;
        nqh[(c - 1) % 64] = 1'b0;
      end
    end
  end

  // ---------------- directed command with literal expectations ----------------
  task automatic cmd_directed(input string tag, input logic set_v,
                              input logic exp_q, input logic exp_err,
                              input bit clr_at_done);
    int nlow, nother, first_low, done_at;
    nlow = 0; nother = 0; first_low = 0; done_at = 0;
    chk({tag, "_ready_before"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_set   = set_v;
    tick();
    req_valid = 1'b0;
    req_set   = ~set_v;
    for (int kk = 1; kk <= 7; kk++) begin
      if ((set_v ? nS : nR) == 1'b0) begin
        nlow++;
        if (first_low == 0) first_low = kk;
      end
      if ((set_v ? nR : nS) == 1'b0) nother++;
      if (done) done_at = kk;
      if (kk == 6 && clr_at_done) err_clr = 1'b1;
      if (kk < 7) tick();
      err_clr = 1'b0;
    end
    chk_int({tag, "_pulse_len"},   nlow, 2);
    chk_int({tag, "_pulse_first"}, first_low, 1);
    chk_int({tag, "_other_low"},   nother, 0);
    chk_int({tag, "_done_at"},     done_at, 6);
    chk({tag, "_ready_after"}, req_ready, 1'b1);
    chk({tag, "_q_state"},     q_state, exp_q);
    chk({tag, "_err"},         err, exp_err);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc_times[$];
    int start_acc;
    int budget;
    int r;

    nRST = 1'b0; req_valid = 1'b0; req_set = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_nS",    nS,        1'b1);
    chk("rst_nR",    nR,        1'b1);
    chk("rst_done",  done,      1'b0);
    chk("rst_err",   err,       1'b0);
    chk("rst_qst",   q_state,   1'b0);
    nRST = 1'b1;
    tick();

    // Set then reset with a healthy latch.
    cmd_directed("set1", 1'b1, 1'b1, 1'b0, 0);
    cmd_directed("rst1", 1'b0, 1'b0, 1'b0, 0);

    // Stuck latch: error is sticky until cleared.
    stuck = 1'b1;
    cmd_directed("stuck", 1'b1, 1'b0, 1'b1, 0);
    repeat (3) tick();
    chk("stuck_sticky", err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("stuck_cleared", err, 1'b0);

    // Clear coincident with an erroring check loses to the set.
    cmd_directed("clr_coinc", 1'b1, 1'b0, 1'b1, 1);
    stuck = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("coinc_cleared", err, 1'b0);

    // Forbidden pair flags an error even though Q matches.
    forbid = 1'b1;
    cmd_directed("forbid", 1'b1, 1'b1, 1'b1, 0);
    forbid = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();

    // Reset during the second strobe cycle.
    req_valid = 1'b1; req_set = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("mid_strobe1", nR, 1'b0);
    tick();
    nRST = 1'b0;
    tick();
    chk("mid_rst_nS",    nS,        1'b1);
    chk("mid_rst_nR",    nR,        1'b1);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_done",  done,      1'b0);
    nRST = 1'b1;
    tick();
    cmd_directed("after_rst", 1'b1, 1'b1, 1'b0, 0);

    // Continuous valid with alternating targets.
    req_valid = 1'b1; req_set = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (req_ready) acc_times.push_back(i);
      tick();
      if (acc_times.size() > 0 && acc_times[acc_times.size() - 1] == i) req_set = ~req_set;
    end
    req_valid = 1'b0;
    chk_int("thru_count", (acc_times.size() >= 8) ? 1 : 0, 1);
    for (int i = 1; i < acc_times.size(); i++)
      chk_int("thru_gap", acc_times[i] - acc_times[i - 1], 7);
    repeat (8) tick();

    // Randomized run.
    start_acc = n_acc;
    budget = 0;
    while ((n_acc - start_acc) < 1000 && budget < 20000) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_set   = 1'($urandom_range(0, 1));
      err_clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) begin
        r = $urandom_range(0, 5);
        stuck  = (r == 4);
        forbid = (r == 5);
      end
      tick();
      budget++;
    end
    chk_int("random_cmds_reached", ((n_acc - start_acc) >= 1000) ? 1 : 0, 1);
    req_valid = 1'b0; err_clr = 1'b0; stuck = 1'b0; forbid = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
